// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ requesters.
// Optional WAIT watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   req_done,
  output logic              spi_start,
  output logic [7:0]        spi_data,
  input  logic              spi_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StGrant, StWait, StRelease} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   win_idx;
  logic              timeout;
  int unsigned       cand;

  // Scan downward so the last hit is the first set bit above last_q (mod NREQ).
  always_comb begin
    win_idx = last_q;
    cand    = 0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      cand = (32'(last_q) + i) % NREQ;
      if (req[cand[IdxW-1:0]]) win_idx = cand[IdxW-1:0];
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StGrant) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout     = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYC));
  // A done arriving together with the timeout completes normally.
  assign timeout_err = timeout && !spi_done;
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    spi_data_d = spi_data_q;
    last_d     = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d          = StGrant;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          spi_data_d       = req_data[{win_idx, 3'b000} +: 8];
          last_d           = win_idx;
        end
      end
      StGrant: state_d = StWait;
      StWait: begin
        if (spi_done || timeout) state_d = StRelease;
      end
      StRelease: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      spi_data_q <= 8'h00;
      last_q     <= IdxW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      spi_data_q <= spi_data_d;
      last_q     <= last_d;
    end
  end

  assign grant     = grant_q;
  assign spi_data  = spi_data_q;
  assign spi_start = (state_q == StGrant);
  assign req_done  = (state_q == StRelease) ? grant_q : '0;
  assign busy      = (state_q != StIdle);

endmodule
